uart_tx_drainer: RTL and testbench
==================================

// Module: uart_tx_drainer
// PURPOSE
//  Output stage downstream of the core's out_req/out_data/out_busy port. It buffers the bytes the core
//  outputs in a small FIFO and drains them, one at a time, to an AXI UART Lite TX FIFO over an AXI4-lite
//  master. Before each write it polls the UART status register. out_busy throttles the core when the
//  buffer is full.
// PARAMETERS
//  UART_BASE   32'h4060_0000  AXI base address of the UART Lite
//  FIFO_LOG    4              log2 of buffer depth (depth = 16)
// PORTS
//  clk          in   1       single clock, all logic rising-edge
//  rst          in   1       synchronous, active-high reset
//  out_req      in   1       core pushes out_data[7:0] this cycle
//  out_data     in   REG_W   byte in [7:0]; upper bits ignored
//  out_busy     out  1       buffer full; core must not assert out_req
//  overflow     out  1       sticky: out_req seen while out_busy
//  axi_err      out  1       sticky: a bresp other than OKAY was received
//  axi_aw*/w*/b*/ar*/r*      AXI4-lite master, 32-bit addr/data, same names/widths as io_controller
// BEHAVIOUR
//  Reset values
//   - clk and rst: one clock; rst is synchronous, active-high.
//   - On rst: FIFO emptied, FSM=IDLE, every *valid/*ready=0, out_busy=0, overflow=0, axi_err=0.
//  Fixed outputs
//   - axi_awprot=axi_arprot=3'b000.
//   - axi_araddr=UART_BASE+`UART_STAT_OFS (0x8); axi_awaddr=UART_BASE+`UART_TX_OFS (0x4).
//   - axi_wdata={24'b0,head}; axi_wstrb=4'b0001.
//  Buffer
//   - Push when out_req && !out_busy.
//   - out_busy = (count == 2**FIFO_LOG), from registered state only.
//   - Push while full: byte dropped, overflow set; a same-cycle pop does not rescue it.
//   - Simultaneous push and pop when not full: count unchanged.
//   - Pointers wrap modulo depth; count is FIFO_LOG+1 bits wide.
//  FSM, one transaction at a time
//   IDLE:  FIFO non-empty -> RD_A on the next edge. A byte pushed at cycle t raises arvalid at t+1.
//   RD_A:  arvalid=1; arready -> RD_D (arvalid drops the same edge).
//   RD_D:  rready=1; on rvalid:
//           - rresp!=OKAY or rdata[`UART_TXFULL_BIT=3]=1 -> RD_A (re-poll, no limit)
//           - else -> WR
//   WR:    awvalid and wvalid raised together. Each drops independently on its own ready.
//          Both accepted (same or different cycles) -> WR_B.
//   WR_B:  bready=1; on bvalid: pop head, set axi_err if bresp!=OKAY (byte is not retried) -> IDLE.
//  Handshake rules
//   - Valids never drop before ready.
//   - Address and data are held stable while valid.
//   - Head is stable from WR until pop; pushes never alter head.
//  Latency
//   - With zero-wait slave: push at t -> arvalid t+1, rvalid t+2/rready, awvalid+wvalid t+3,
//     bvalid t+4 -> pop; minimum 4 cycles per byte.
//  Reset mid-transaction
//   - Valids drop next edge; the transaction is abandoned (interconnect shares rst); buffered bytes are lost.
// STRUCTURE
//  - common_params.h gains `UART_STAT_OFS, `UART_TX_OFS, `UART_TXFULL_BIT, `AXI_RESP_OKAY (2'b00).
//    It already holds `REG_W/`WORD_W.
//  - FSM state encodings are localparams here.
//  - Sub-module sync_fifo #(WIDTH=8, LOG=FIFO_LOG): push/pop/head/count/full/empty.
//    Reusable by io_controller's input side.
//  - Top holds the AXI FSM only.
// TESTING
//  1 Single byte
//    - Stimulus: out_data=32'hAB after reset; zero-wait slave; status reads 0.
//    - Required: exactly one write, awaddr=UART_BASE+4, wdata=32'hAB, wstrb=1; head popped 4 cycles after push.
//  2 TX-full polling
//    - Stimulus: status returns bit3=1 three times, then 0.
//    - Required: 4 reads, then 1 write; no write while full.
//  3 Fill the buffer
//    - Stimulus: 17 back-to-back pushes while the slave stalls arready.
//    - Required: out_busy=1 after the 16th push; 17th dropped and overflow=1;
//      after release, bytes 0..15 are written in order.
//  4 Split write handshake
//    - Stimulus: wready arrives 3 cycles after awready.
//    - Required: awvalid drops after awready, wvalid holds until wready, single bvalid, one pop.
//  5 Reset mid-write (awvalid=1)
//    - Stimulus: assert rst while awvalid=1.
//    - Required: all valids 0 next edge, out_busy=0, FIFO empty; a fresh byte afterwards completes normally.
//  6 Error response
//    - Stimulus: bresp=2'b10 on byte 0.
//    - Required: axi_err=1 (sticky), byte 0 not retried, byte 1 still sent.

Source files
------------

// File: rtl/uart_tx_drainer_pkg.sv
// Shared constants and state type for the UART TX drainer: register offsets,
// status bit positions, AXI response codes and the drain FSM encoding.
package uart_tx_drainer_pkg;

    localparam int REG_W  = 32;
    localparam int WORD_W = 32;

    localparam logic [31:0] UART_STAT_OFS   = 32'h0000_0008;
    localparam logic [31:0] UART_TX_OFS     = 32'h0000_0004;
    localparam int          UART_TXFULL_BIT = 3;
    localparam logic [1:0]  AXI_RESP_OKAY   = 2'b00;

    typedef enum logic [2:0] {
        ST_IDLE = 3'd0,
        ST_RD_A = 3'd1,
        ST_RD_D = 3'd2,
        ST_WR   = 3'd3,
        ST_WR_B = 3'd4
    } drain_state_t;

endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with synchronous active-high reset. The head is read
// combinationally from registered state, so it only moves on a pop.
module sync_fifo #(
    parameter int WIDTH = 8,
    parameter int LOG   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             push,
    input  logic             pop,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] head,
    output logic [LOG:0]     count,
    output logic             full,
    output logic             empty
);

    localparam int DEPTH = 2 ** LOG;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [LOG-1:0]   wr_ptr;
    logic [LOG-1:0]   rd_ptr;
    logic             do_push;
    logic             do_pop;

    // A push while full is dropped even if a pop happens in the same cycle.
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    assign full  = (count == (LOG+1)'(DEPTH));
    assign empty = (count == '0);
    assign head  = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= data_in;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            case ({do_push, do_pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

endmodule

// File: rtl/uart_tx_drainer.sv
// Buffers core output bytes and drains them one at a time to an AXI UART Lite
// TX FIFO, polling the status register before every write.
//
//  state   | meaning
//  --------+-----------------------------------------------------------
//  ST_IDLE | waiting for a buffered (or same-cycle pushed) byte
//  ST_RD_A | status read address phase, arvalid high
//  ST_RD_D | status read data phase, rready high; re-poll if TX full
//  ST_WR   | awvalid/wvalid raised together, each dropped on its ready
//  ST_WR_B | bready high; pop head on response, flag non-OKAY
module uart_tx_drainer
    import uart_tx_drainer_pkg::*;
#(
    parameter logic [31:0] UART_BASE = 32'h4060_0000,
    parameter int          FIFO_LOG  = 4
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                out_req,
    input  logic [REG_W-1:0]    out_data,
    output logic                out_busy,
    output logic                overflow,
    output logic                axi_err,
    output logic [WORD_W-1:0]   axi_awaddr,
    output logic [2:0]          axi_awprot,
    output logic                axi_awvalid,
    input  logic                axi_awready,
    output logic [WORD_W-1:0]   axi_wdata,
    output logic [WORD_W/8-1:0] axi_wstrb,
    output logic                axi_wvalid,
    input  logic                axi_wready,
    input  logic [1:0]          axi_bresp,
    input  logic                axi_bvalid,
    output logic                axi_bready,
    output logic [WORD_W-1:0]   axi_araddr,
    output logic [2:0]          axi_arprot,
    output logic                axi_arvalid,
    input  logic                axi_arready,
    input  logic [WORD_W-1:0]   axi_rdata,
    input  logic [1:0]          axi_rresp,
    input  logic                axi_rvalid,
    output logic                axi_rready
);

    drain_state_t    state;
    logic            fifo_push;
    logic            fifo_pop;
    logic [7:0]      fifo_head;
    logic [FIFO_LOG:0] fifo_count;
    logic            fifo_full;
    logic            fifo_empty;
    logic            unused_bits;

    assign fifo_push = out_req && !out_busy;
    assign fifo_pop  = (state == ST_WR_B) && axi_bready && axi_bvalid;
    assign out_busy  = fifo_full;

    assign axi_awprot = 3'b000;
    assign axi_arprot = 3'b000;
    assign axi_araddr = UART_BASE + UART_STAT_OFS;
    assign axi_awaddr = UART_BASE + UART_TX_OFS;
    assign axi_wdata  = {{(WORD_W-8){1'b0}}, fifo_head};
    assign axi_wstrb  = (WORD_W/8)'(1);

    assign unused_bits = ^{out_data[REG_W-1:8], axi_rdata[WORD_W-1:UART_TXFULL_BIT+1],
                           axi_rdata[UART_TXFULL_BIT-1:0], fifo_count};

    sync_fifo #(
        .WIDTH (8),
        .LOG   (FIFO_LOG)
    ) u_fifo (
        .clk     (clk),
        .rst     (rst),
        .push    (fifo_push),
        .pop     (fifo_pop),
        .data_in (out_data[7:0]),
        .head    (fifo_head),
        .count   (fifo_count),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state       <= ST_IDLE;
            axi_arvalid <= 1'b0;
            axi_rready  <= 1'b0;
            axi_awvalid <= 1'b0;
            axi_wvalid  <= 1'b0;
            axi_bready  <= 1'b0;
            overflow    <= 1'b0;
            axi_err     <= 1'b0;
        end else begin
            if (out_req && out_busy) begin
                overflow <= 1'b1;
            end
            case (state)
                ST_IDLE: begin
                    // Looking at the push itself saves a cycle of latency.
                    if (!fifo_empty || fifo_push) begin
                        axi_arvalid <= 1'b1;
                        state       <= ST_RD_A;
                    end
                end
                ST_RD_A: begin
                    if (axi_arready) begin
                        axi_arvalid <= 1'b0;
                        axi_rready  <= 1'b1;
                        state       <= ST_RD_D;
                    end
                end
                ST_RD_D: begin
                    if (axi_rvalid) begin
                        axi_rready <= 1'b0;
                        if (axi_rresp != AXI_RESP_OKAY || axi_rdata[UART_TXFULL_BIT]) begin
                            axi_arvalid <= 1'b1;
                            state       <= ST_RD_A;
                        end else begin
                            axi_awvalid <= 1'b1;
                            axi_wvalid  <= 1'b1;
                            state       <= ST_WR;
                        end
                    end
                end
                ST_WR: begin
                    if (axi_awready) begin
                        axi_awvalid <= 1'b0;
                    end
                    if (axi_wready) begin
                        axi_wvalid <= 1'b0;
                    end
                    if ((!axi_awvalid || axi_awready) && (!axi_wvalid || axi_wready)) begin
                        axi_bready <= 1'b1;
                        state      <= ST_WR_B;
                    end
                end
                ST_WR_B: begin
                    if (axi_bvalid) begin
                        axi_bready <= 1'b0;
                        if (axi_bresp != AXI_RESP_OKAY) begin
                            axi_err <= 1'b1;
                        end
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    state <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_drainer.sv
// Directed plus randomized bench for uart_tx_drainer against a queue model of
// the byte buffer and a behavioural AXI-lite UART slave.
module tb_uart_tx_drainer;
    import uart_tx_drainer_pkg::*;

    localparam logic [31:0] BASE = 32'h4060_0000;

    logic        clk = 1'b0;
    logic        rst;
    logic        out_req;
    logic [31:0] out_data;
    logic        out_busy, overflow, axi_err;
    logic [31:0] axi_awaddr, axi_wdata, axi_araddr, axi_rdata;
    logic [2:0]  axi_awprot, axi_arprot;
    logic [3:0]  axi_wstrb;
    logic        axi_awvalid, axi_awready, axi_wvalid, axi_wready;
    logic [1:0]  axi_bresp, axi_rresp;
    logic        axi_bvalid, axi_bready, axi_arvalid, axi_arready, axi_rvalid, axi_rready;

    always #5 clk = ~clk;

    // slave controls and model state
    logic        ar_en = 1'b1, aw_en = 1'b1, w_en = 1'b1;
    logic [31:0] cur_stat = 32'h0;
    logic [1:0]  cur_bresp = 2'b00;
    logic        last_full = 1'b0;
    bit          rand_stat = 1'b0;
    logic [31:0] stat_q[$];
    logic [1:0]  bresp_q[$];
    logic [7:0]  exp_q[$];
    bit          exp_overflow = 1'b0, exp_err = 1'b0;
    int          n_checks = 0, n_err = 0;
    int          n_reads = 0, n_writes = 0, n_aw = 0, n_b = 0;
    int          cyc = 0, push_cyc = 0, pop_cyc = 0;

    assign axi_arready = axi_arvalid & ar_en;
    assign axi_rvalid  = axi_rready;
    assign axi_rdata   = cur_stat;
    assign axi_rresp   = 2'b00;
    assign axi_awready = axi_awvalid & aw_en;
    assign axi_wready  = axi_wvalid & w_en;
    assign axi_bvalid  = axi_bready;
    assign axi_bresp   = cur_bresp;

    uart_tx_drainer dut (
        .clk(clk), .rst(rst), .out_req(out_req), .out_data(out_data),
        .out_busy(out_busy), .overflow(overflow), .axi_err(axi_err),
        .axi_awaddr(axi_awaddr), .axi_awprot(axi_awprot), .axi_awvalid(axi_awvalid),
        .axi_awready(axi_awready), .axi_wdata(axi_wdata), .axi_wstrb(axi_wstrb),
        .axi_wvalid(axi_wvalid), .axi_wready(axi_wready), .axi_bresp(axi_bresp),
        .axi_bvalid(axi_bvalid), .axi_bready(axi_bready), .axi_araddr(axi_araddr),
        .axi_arprot(axi_arprot), .axi_arvalid(axi_arvalid), .axi_arready(axi_arready),
        .axi_rdata(axi_rdata), .axi_rresp(axi_rresp), .axi_rvalid(axi_rvalid),
        .axi_rready(axi_rready)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Advance the read/write responses just after the edge that consumed them.
    bit r_hs, b_hs, rd_bit;
    always @(posedge clk) begin
        r_hs   = !rst && axi_rvalid && axi_rready;
        b_hs   = !rst && axi_bvalid && axi_bready;
        rd_bit = axi_rdata[3];
        #1;
        if (r_hs) begin
            last_full = rd_bit;
            if (stat_q.size() > 0)  cur_stat = stat_q.pop_front();
            else if (rand_stat)     cur_stat = ($urandom_range(0, 3) == 0) ? 32'h8 : 32'h0;
            else                    cur_stat = 32'h0;
        end
        if (b_hs) begin
            cur_bresp = (bresp_q.size() > 0) ? bresp_q.pop_front() : 2'b00;
        end
    end

    bit p_ar = 1'b0, p_aw = 1'b0, p_w = 1'b0;
    always @(negedge clk) begin
        if (rst) begin
            p_ar = 1'b0; p_aw = 1'b0; p_w = 1'b0;
        end else begin
            if (p_ar) chk("ar_hold", axi_arvalid, 1);
            if (p_aw) chk("aw_hold", axi_awvalid, 1);
            if (p_w)  chk("w_hold", axi_wvalid, 1);
            if (axi_arvalid && axi_arready) begin
                n_reads++;
                chk("araddr", axi_araddr, BASE + 32'h8);
            end
            if (axi_awvalid && axi_awready) begin
                n_aw++;
                chk("awaddr", axi_awaddr, BASE + 32'h4);
            end
            if (axi_wvalid && axi_wready) begin
                n_writes++;
                chk("no_write_while_full", last_full, 0);
                chk("write_expected", exp_q.size() > 0, 1);
                if (exp_q.size() > 0) chk("wdata", axi_wdata, {24'h0, exp_q[0]});
                chk("wstrb", axi_wstrb, 4'b0001);
            end
            if (axi_bvalid && axi_bready) begin
                n_b++;
                pop_cyc = cyc;
                if (axi_bresp != 2'b00) exp_err = 1'b1;
                if (exp_q.size() > 0) void'(exp_q.pop_front());
            end
            p_ar = axi_arvalid && !axi_arready;
            p_aw = axi_awvalid && !axi_awready;
            p_w  = axi_wvalid && !axi_wready;
        end
    end

    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic drive_cycle(input bit req, input logic [7:0] b);
        logic [31:0] r;
        r = $urandom;
        chk("out_busy", out_busy, exp_q.size() == 16);
        out_req  = req;
        out_data = {r[31:8], b};
        if (req) begin
            if (exp_q.size() < 16) begin
                exp_q.push_back(b);
                push_cyc = cyc;
            end else begin
                exp_overflow = 1'b1;
            end
        end
        tick();
        out_req = 1'b0;
    endtask

    task automatic clear_model();
        exp_q.delete(); stat_q.delete(); bresp_q.delete();
        cur_stat = 32'h0; cur_bresp = 2'b00; last_full = 1'b0;
        exp_overflow = 1'b0; exp_err = 1'b0;
    endtask

    task automatic do_reset();
        rst = 1'b1; out_req = 1'b0;
        tick();
        chk("rst_valids", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 0);
        chk("rst_flags", {out_busy, overflow, axi_err}, 0);
        tick();
        rst = 1'b0;
        clear_model();
    endtask

    task automatic drain(input int budget);
        int i = 0;
        while (exp_q.size() != 0 && i < budget) begin
            tick();
            i++;
        end
        chk("drain_done", exp_q.size(), 0);
        repeat (3) tick();
        chk("flags", {overflow, axi_err}, {exp_overflow, exp_err});
    endtask

    initial begin
        int r0, w0, b0, a0, i;
        rst = 1'b1; out_req = 1'b0; out_data = '0;
        @(posedge clk); #2;
        do_reset();

        // single byte, latency and fixed fields
        r0 = n_reads; w0 = n_writes;
        drive_cycle(1'b1, 8'hAB);
        chk("t1_arvalid_t1", axi_arvalid, 1);
        chk("t1_prot", {axi_awprot, axi_arprot}, 0);
        drain(50);
        chk("t1_latency", pop_cyc - push_cyc, 4);
        chk("t1_reads", n_reads - r0, 1);
        chk("t1_writes", n_writes - w0, 1);

        // TX-full polling
        cur_stat = 32'h8;
        stat_q.push_back(32'h8); stat_q.push_back(32'h8); stat_q.push_back(32'h0);
        r0 = n_reads; w0 = n_writes;
        drive_cycle(1'b1, 8'($urandom));
        drain(100);
        chk("t2_reads", n_reads - r0, 4);
        chk("t2_writes", n_writes - w0, 1);

        // fill the buffer with arready stalled
        ar_en = 1'b0;
        w0 = n_writes;
        for (int k = 0; k < 17; k++) drive_cycle(1'b1, 8'(k));
        chk("t3_busy", out_busy, exp_q.size() == 16);
        chk("t3_overflow", overflow, exp_overflow);
        ar_en = 1'b1;
        drain(400);
        chk("t3_writes", n_writes - w0, 16);
        chk("t3_busy_clear", out_busy, 0);

        // split write handshake
        w_en = 1'b0;
        a0 = n_aw; b0 = n_b; w0 = n_writes;
        drive_cycle(1'b1, 8'h5A);
        i = 0;
        while (n_aw == a0 && i < 20) begin tick(); i++; end
        chk("t4_aw_seen", n_aw - a0, 1);
        for (int k = 0; k < 3; k++) begin
            chk("t4_awvalid_low", axi_awvalid, 0);
            chk("t4_wvalid_held", axi_wvalid, 1);
            chk("t4_no_b", n_b - b0, 0);
            tick();
        end
        w_en = 1'b1;
        drain(50);
        chk("t4_one_b", n_b - b0, 1);
        chk("t4_writes", n_writes - w0, 1);

        // reset while awvalid is high
        aw_en = 1'b0; w_en = 1'b0;
        drive_cycle(1'b1, 8'h11);
        drive_cycle(1'b1, 8'h22);
        drive_cycle(1'b1, 8'h33);
        i = 0;
        while (!axi_awvalid && i < 20) begin tick(); i++; end
        chk("t5_awvalid", axi_awvalid, 1);
        rst = 1'b1;
        tick();
        chk("t5_valids", {axi_arvalid, axi_rready, axi_awvalid, axi_wvalid, axi_bready}, 0);
        chk("t5_busy", out_busy, 0);
        rst = 1'b0;
        clear_model();
        aw_en = 1'b1; w_en = 1'b1;
        for (int k = 0; k < 5; k++) begin
            tick();
            chk("t5_fifo_empty", axi_arvalid, 0);
        end
        w0 = n_writes;
        drive_cycle(1'b1, 8'h44);
        drain(50);
        chk("t5_fresh_write", n_writes - w0, 1);

        // error response on byte 0
        cur_bresp = 2'b10;
        w0 = n_writes;
        drive_cycle(1'b1, 8'hE0);
        drive_cycle(1'b1, 8'hE1);
        drain(100);
        chk("t6_axi_err", axi_err, exp_err);
        chk("t6_writes", n_writes - w0, 2);
        drive_cycle(1'b1, 8'hE2);
        drain(50);
        chk("t6_err_sticky", axi_err, exp_err);

        // randomized traffic with stalls and TX-full polling
        rand_stat = 1'b1;
        for (int k = 0; k < 400; k++) begin
            ar_en = ($urandom_range(0, 3) != 0);
            aw_en = ($urandom_range(0, 3) != 0);
            w_en  = ($urandom_range(0, 3) != 0);
            drive_cycle($urandom_range(0, 9) < 4, 8'($urandom));
        end
        ar_en = 1'b1; aw_en = 1'b1; w_en = 1'b1;
        rand_stat = 1'b0;
        drain(3000);

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2_000_000;
        n_err++;
        $display("FAIL watchdog observed=timeout expected=finish");
        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $fatal(1, "watchdog");
    end

endmodule
